// File: rtl/cdc_2ch_router.sv
// Two-channel byte router between usb_cdc OUT and IN bulk endpoints.
// Supports straight, crossed and merge (burst round-robin onto IN0) routing with a drain on mode change.
module cdc_2ch_router #(
    parameter int unsigned BURST = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] mode_i,
    input  logic [7:0] out0_data_i,
    input  logic       out0_valid_i,
    output logic       out0_ready_o,
    input  logic [7:0] out1_data_i,
    input  logic       out1_valid_i,
    output logic       out1_ready_o,
    output logic [7:0] in0_data_o,
    output logic       in0_valid_o,
    input  logic       in0_ready_i,
    output logic [7:0] in1_data_o,
    output logic       in1_valid_o,
    input  logic       in1_ready_i,
    output logic       grant_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        STRAIGHT,
        CROSS,
        MERGE,
        DRAIN
    } state_t;

    localparam logic [6:0] BURST_MAX = 7'(BURST);
    localparam logic [6:0] BURST_M1  = 7'(BURST - 1);

    state_t     state, state_next;
    logic [1:0] mode_q;
    logic       grant, grant_next;
    logic [6:0] count, count_next;

    logic       v0, v1;
    logic [7:0] d0, d1;
    logic       load0, load1;
    logic       wr0, wr1;
    logic [7:0] wd0, wd1;

    logic       g_valid, o_valid, accept, full, rotate;

    assign load0 = !v0 || in0_ready_i;
    assign load1 = !v1 || in1_ready_i;

    always_comb begin
        state_next   = state;
        out0_ready_o = 1'b0;
        out1_ready_o = 1'b0;
        wr0          = 1'b0;
        wr1          = 1'b0;
        wd0          = out0_data_i;
        wd1          = out1_data_i;
        grant_next   = 1'b0;
        count_next   = '0;
        g_valid      = grant ? out1_valid_i : out0_valid_i;
        o_valid      = grant ? out0_valid_i : out1_valid_i;
        accept       = 1'b0;
        full         = 1'b0;
        rotate       = 1'b0;

        case (state)
            IDLE: begin
                case (mode_i)
                    2'd0:    state_next = STRAIGHT;
                    2'd1:    state_next = CROSS;
                    2'd2:    state_next = MERGE;
                    default: state_next = IDLE;
                endcase
            end
            STRAIGHT: begin
                out0_ready_o = load0;
                out1_ready_o = load1;
                wr0          = out0_valid_i && load0;
                wr1          = out1_valid_i && load1;
                if (mode_i != mode_q) state_next = DRAIN;
            end
            CROSS: begin
                out0_ready_o = load1;
                out1_ready_o = load0;
                wr1          = out0_valid_i && load1;
                wd1          = out0_data_i;
                wr0          = out1_valid_i && load0;
                wd0          = out1_data_i;
                if (mode_i != mode_q) state_next = DRAIN;
            end
            MERGE: begin
                accept = g_valid && load0;
                if (grant) begin
                    out1_ready_o = load0;
                    wd0          = out1_data_i;
                end else begin
                    out0_ready_o = load0;
                end
                wr0 = accept;
                // Burst limit counts the byte being accepted this cycle, so the
                // limit-reaching byte and the rotation share one cycle.
                full   = (count == BURST_MAX) || (accept && count == BURST_M1);
                rotate = o_valid && (full || !g_valid);
                grant_next = grant;
                count_next = count;
                if (rotate) begin
                    grant_next = ~grant;
                    count_next = '0;
                end else if (accept && count != BURST_MAX) begin
                    count_next = count + 7'd1;
                end
                if (mode_i != mode_q) state_next = DRAIN;
            end
            DRAIN: begin
                if (!v0 && !v1) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            mode_q <= '0;
            grant  <= 1'b0;
            count  <= '0;
            v0     <= 1'b0;
            v1     <= 1'b0;
            d0     <= '0;
            d1     <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            count <= count_next;
            if (state == IDLE && mode_i != 2'd3) mode_q <= mode_i;
            if (wr0) begin
                v0 <= 1'b1;
                d0 <= wd0;
            end else if (in0_ready_i) begin
                v0 <= 1'b0;
            end
            if (wr1) begin
                v1 <= 1'b1;
                d1 <= wd1;
            end else if (in1_ready_i) begin
                v1 <= 1'b0;
            end
        end
    end

    assign in0_data_o  = d0;
    assign in0_valid_o = v0;
    assign in1_data_o  = d1;
    assign in1_valid_o = v1;
    assign grant_o     = grant;
    assign busy_o      = v0 || v1;

endmodule

// File: tb/tb_cdc_2ch_router.sv
// Directed self-checking bench for cdc_2ch_router (BURST = 8).
// Inputs are driven and outputs sampled on the falling edge.
module tb_cdc_2ch_router;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'd3;
    logic [7:0] out0_data = '0, out1_data = '0;
    logic       out0_valid = 1'b0, out1_valid = 1'b0;
    logic       out0_ready, out1_ready;
    logic [7:0] in0_data, in1_data;
    logic       in0_valid, in1_valid;
    logic       in0_ready = 1'b1, in1_ready = 1'b1;
    logic       grant, busy;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    cdc_2ch_router #(.BURST(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mode_i      (mode),
        .out0_data_i (out0_data),
        .out0_valid_i(out0_valid),
        .out0_ready_o(out0_ready),
        .out1_data_i (out1_data),
        .out1_valid_i(out1_valid),
        .out1_ready_o(out1_ready),
        .in0_data_o  (in0_data),
        .in0_valid_o (in0_valid),
        .in0_ready_i (in0_ready),
        .in1_data_o  (in1_data),
        .in1_valid_o (in1_valid),
        .in1_ready_i (in1_ready),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    task automatic go_idle;
        mode = 2'd3;
        out0_valid = 1'b0;
        out1_valid = 1'b0;
        in0_ready = 1'b1;
        in1_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mode = 2'd3;
        repeat (2) @(negedge clk);
        nvec++;
        if ({in0_valid, in1_valid, busy, grant, out0_ready, out1_ready} !== 6'b0) begin
            nerr++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {in0_valid, in1_valid, busy, grant, out0_ready, out1_ready});
        end
        nvec++;
        if ({in0_data, in1_data} !== 16'h0000) begin
            nerr++;
            $display("FAIL reset_data: got %h expected 0000", {in0_data, in1_data});
        end
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if ({out0_ready, out1_ready} !== 2'b00) begin
            nerr++;
            $display("FAIL idle_ready: got %b expected 00", {out0_ready, out1_ready});
        end
    endtask

    task automatic test_straight;
        logic [7:0] e0, e1;
        mode = 2'd0;
        @(negedge clk);
        for (int k = 0; k <= 8; k++) begin
            if (k >= 1 && k <= 7) begin
                e0 = 8'h01 + 8'(k - 1);
                e1 = 8'h81 + 8'(k - 1);
                nvec++;
                if ({in0_valid, in0_data, in1_valid, in1_data} !== {1'b1, e0, 1'b1, e1}) begin
                    nerr++;
                    $display("FAIL straight_out[%0d]: got %b/%h %b/%h expected 1/%h 1/%h",
                             k, in0_valid, in0_data, in1_valid, in1_data, e0, e1);
                end
            end else begin
                nvec++;
                if ({in0_valid, in1_valid} !== 2'b00) begin
                    nerr++;
                    $display("FAIL straight_empty[%0d]: got %b expected 00", k, {in0_valid, in1_valid});
                end
            end
            if (k < 7) begin
                out0_data = 8'h01 + 8'(k);
                out1_data = 8'h81 + 8'(k);
                out0_valid = 1'b1;
                out1_valid = 1'b1;
                #1;
                nvec++;
                if ({out0_ready, out1_ready} !== 2'b11) begin
                    nerr++;
                    $display("FAIL straight_ready[%0d]: got %b expected 11", k, {out0_ready, out1_ready});
                end
            end else begin
                out0_valid = 1'b0;
                out1_valid = 1'b0;
            end
            @(negedge clk);
        end
        go_idle();
    endtask

    task automatic test_cross_backpressure;
        logic [0:6] exp_rdy = 7'b1100011;
        logic [0:8] exp_v1  = 9'b011111110;
        logic [7:0] exp_d1 [0:8] = '{8'h00, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h03, 8'h04, 8'h00};
        int idx = 0;
        logic hs;
        mode = 2'd1;
        @(negedge clk);
        for (int c = 0; c <= 8; c++) begin
            in1_ready = !(c >= 2 && c <= 4);
            in0_ready = 1'b1;
            out1_valid = 1'b0;
            out0_valid = (idx < 4);
            out0_data = 8'h01 + 8'(idx);
            #1;
            if (out0_valid && c <= 6) begin
                nvec++;
                if (out0_ready !== exp_rdy[c]) begin
                    nerr++;
                    $display("FAIL cross_ready[%0d]: got %b expected %b", c, out0_ready, exp_rdy[c]);
                end
            end
            nvec++;
            if (in1_valid !== exp_v1[c] || in0_valid !== 1'b0) begin
                nerr++;
                $display("FAIL cross_valid[%0d]: got in1=%b in0=%b expected in1=%b in0=0",
                         c, in1_valid, in0_valid, exp_v1[c]);
            end
            if (exp_v1[c]) begin
                nvec++;
                if (in1_data !== exp_d1[c]) begin
                    nerr++;
                    $display("FAIL cross_data[%0d]: got %h expected %h", c, in1_data, exp_d1[c]);
                end
            end
            hs = out0_valid && out0_ready;
            @(negedge clk);
            if (hs) idx++;
        end
        nvec++;
        if (idx != 4) begin
            nerr++;
            $display("FAIL cross_count: got %0d expected 4", idx);
        end
        go_idle();
    endtask

    task automatic test_merge_rotation;
        logic [7:0] exp [0:19] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
                                   8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
                                   8'h19, 8'h1A, 8'h29, 8'h2A};
        logic [7:0] got [$];
        int i0 = 0, i1 = 0, in1_seen = 0;
        logic hs0, hs1, eg;
        mode = 2'd2;
        in0_ready = 1'b1;
        in1_ready = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= 24; c++) begin
            if (in0_valid) got.push_back(in0_data);
            if (in1_valid) in1_seen++;
            out0_valid = (i0 < 10);
            out0_data = 8'h11 + 8'(i0);
            out1_valid = (i1 < 10);
            out1_data = 8'h21 + 8'(i1);
            #1;
            if (c <= 20) begin
                eg = (c >= 8 && c <= 15) || c >= 19;
                nvec++;
                if (grant !== eg) begin
                    nerr++;
                    $display("FAIL merge_grant[%0d]: got %b expected %b", c, grant, eg);
                end
            end
            hs0 = out0_valid && out0_ready;
            hs1 = out1_valid && out1_ready;
            @(negedge clk);
            if (hs0) i0++;
            if (hs1) i1++;
        end
        nvec++;
        if (got.size() != 20) begin
            nerr++;
            $display("FAIL merge_count: got %0d expected 20", got.size());
        end
        for (int j = 0; j < 20 && j < got.size(); j++) begin
            nvec++;
            if (got[j] !== exp[j]) begin
                nerr++;
                $display("FAIL merge_data[%0d]: got %h expected %h", j, got[j], exp[j]);
            end
        end
        nvec++;
        if (in1_seen != 0) begin
            nerr++;
            $display("FAIL merge_in1_valid: got %0d cycles expected 0", in1_seen);
        end
        go_idle();
    endtask

    task automatic test_merge_idle_switch;
        logic [7:0] got [$];
        int i1 = 0, in1_seen = 0;
        logic hs1;
        mode = 2'd2;
        @(negedge clk);
        for (int c = 0; c <= 13; c++) begin
            if (in0_valid) got.push_back(in0_data);
            if (in1_valid) in1_seen++;
            if (c == 11) begin
                nvec++;
                if (i1 != 10) begin
                    nerr++;
                    $display("FAIL idle_sw_stall: got %0d accepted expected 10", i1);
                end
            end
            out0_valid = 1'b0;
            out1_valid = (i1 < 10);
            out1_data = 8'h31 + 8'(i1);
            #1;
            nvec++;
            if (c == 0) begin
                if ({grant, out1_ready} !== 2'b00) begin
                    nerr++;
                    $display("FAIL idle_sw_first: got grant/ready %b expected 00", {grant, out1_ready});
                end
            end else if (grant !== 1'b1) begin
                nerr++;
                $display("FAIL idle_sw_grant[%0d]: got %b expected 1", c, grant);
            end
            hs1 = out1_valid && out1_ready;
            @(negedge clk);
            if (hs1) i1++;
        end
        nvec++;
        if (got.size() != 10) begin
            nerr++;
            $display("FAIL idle_sw_count: got %0d expected 10", got.size());
        end
        for (int j = 0; j < 10 && j < got.size(); j++) begin
            nvec++;
            if (got[j] !== 8'h31 + 8'(j)) begin
                nerr++;
                $display("FAIL idle_sw_data[%0d]: got %h expected %h", j, got[j], 8'h31 + 8'(j));
            end
        end
        nvec++;
        if (in1_seen != 0) begin
            nerr++;
            $display("FAIL idle_sw_in1_valid: got %0d cycles expected 0", in1_seen);
        end
        go_idle();
    endtask

    task automatic test_mode_change;
        mode = 2'd0;
        in0_ready = 1'b0;
        in1_ready = 1'b1;
        @(negedge clk);
        out0_valid = 1'b1;
        out0_data = 8'h55;
        out1_valid = 1'b0;
        #1;
        nvec++;
        if (out0_ready !== 1'b1) begin
            nerr++;
            $display("FAIL mc_accept: got %b expected 1", out0_ready);
        end
        @(negedge clk);
        out0_valid = 1'b0;
        mode = 2'd1;
        #1;
        nvec++;
        if ({in0_valid, in0_data, out0_ready} !== {1'b1, 8'h55, 1'b0}) begin
            nerr++;
            $display("FAIL mc_pending: got %b/%h/%b expected 1/55/0", in0_valid, in0_data, out0_ready);
        end
        @(negedge clk);
        out0_valid = 1'b1;
        out0_data = 8'h66;
        #1;
        nvec++;
        if ({out0_ready, out1_ready, busy, in0_valid, in0_data} !== {4'b0011, 8'h55}) begin
            nerr++;
            $display("FAIL mc_drain: got rdy0/rdy1/busy/v0=%b data=%h expected 0011 55",
                     {out0_ready, out1_ready, busy, in0_valid}, in0_data);
        end
        @(negedge clk);
        in0_ready = 1'b1;
        #1;
        nvec++;
        if ({out0_ready, out1_ready, in0_valid, in0_data} !== {3'b001, 8'h55}) begin
            nerr++;
            $display("FAIL mc_drain_hold: got %b/%h expected 001/55",
                     {out0_ready, out1_ready, in0_valid}, in0_data);
        end
        @(negedge clk);
        #1;
        nvec++;
        if ({in0_valid, out0_ready} !== 2'b00) begin
            nerr++;
            $display("FAIL mc_drained: got %b expected 00", {in0_valid, out0_ready});
        end
        @(negedge clk);
        #1;
        nvec++;
        if (out0_ready !== 1'b0) begin
            nerr++;
            $display("FAIL mc_idle: got %b expected 0", out0_ready);
        end
        @(negedge clk);
        #1;
        nvec++;
        if (out0_ready !== 1'b1) begin
            nerr++;
            $display("FAIL mc_cross_ready: got %b expected 1", out0_ready);
        end
        @(negedge clk);
        out0_valid = 1'b0;
        #1;
        nvec++;
        if ({in1_valid, in1_data, in0_valid} !== {1'b1, 8'h66, 1'b0}) begin
            nerr++;
            $display("FAIL mc_cross_out: got %b/%h/%b expected 1/66/0", in1_valid, in1_data, in0_valid);
        end
        go_idle();
    endtask

    task automatic test_reset_mid_transfer;
        mode = 2'd0;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        @(negedge clk);
        out0_valid = 1'b1;
        out0_data = 8'hA1;
        out1_valid = 1'b1;
        out1_data = 8'hB1;
        @(negedge clk);
        out0_valid = 1'b0;
        out1_valid = 1'b0;
        #1;
        nvec++;
        if ({in0_valid, in1_valid, busy} !== 3'b111) begin
            nerr++;
            $display("FAIL rst_pre: got %b expected 111", {in0_valid, in1_valid, busy});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++;
        if ({in0_valid, in1_valid, busy, grant, out0_ready, out1_ready} !== 6'b0) begin
            nerr++;
            $display("FAIL rst_mid_flags: got %b expected 000000",
                     {in0_valid, in1_valid, busy, grant, out0_ready, out1_ready});
        end
        nvec++;
        if ({in0_data, in1_data} !== 16'h0000) begin
            nerr++;
            $display("FAIL rst_mid_data: got %h expected 0000", {in0_data, in1_data});
        end
        mode = 2'd2;
        @(negedge clk);
        out1_valid = 1'b1;
        out1_data = 8'hC1;
        @(negedge clk);
        @(negedge clk);
        out1_valid = 1'b0;
        #1;
        nvec++;
        if ({grant, in0_valid, in0_data} !== {2'b11, 8'hC1}) begin
            nerr++;
            $display("FAIL rst_merge_pre: got %b/%b/%h expected 1/1/c1", grant, in0_valid, in0_data);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++;
        if ({grant, in0_valid, busy} !== 3'b000) begin
            nerr++;
            $display("FAIL rst_merge: got %b expected 000", {grant, in0_valid, busy});
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_straight();
        test_cross_backpressure();
        test_merge_rotation();
        test_merge_idle_switch();
        test_mode_change();
        test_reset_mid_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
